// File: rtl/alu_op_decoder.sv
// alu_op_decoder: RV32I decode stage in front of the ALU.
// Accepts instruction words over a valid/ready handshake. Produces a registered
// bundle downstream over a second valid/ready handshake with one cycle of latency.
// The bundle holds the ALU control code, register indices, immediate and branch
// qualifiers. The register file is not read here.
// Optional feature macro: DECODE_SKID_EN. When it is defined, a 1-entry skid
// buffer sits behind the output register and in_ready comes from a register.
module alu_op_decoder #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   imm,
  output logic              use_imm,
  output logic              is_branch,
  output logic              br_invert,
  output logic              illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b1001;

  typedef struct packed {
    logic [CTRL_W-1:0] alu_control;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic              is_branch;
    logic              br_invert;
    logic              illegal;
  } dec_t;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       bad_s;
  logic       accept_s;
  logic       in_ready_s;
  dec_t       dec_s;
  dec_t       out_r;
  logic       out_valid_r;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign accept_s = in_valid && in_ready_s;

  // Combinational decode of the incoming word into the downstream bundle.
  always_comb begin
    dec_s     = '0;
    dec_s.rs1 = instr[19:15];
    dec_s.rs2 = instr[24:20];
    dec_s.rd  = instr[11:7];
    bad_s     = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == 7'b0000000) begin
          bad_s = 1'b0;
        end else if ((funct7_s == 7'b0100000) &&
                     ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          bad_s = 1'b0;
        end else begin
          bad_s = 1'b1;
        end
        case (funct3_s)
          3'b000:  dec_s.alu_control = funct7_s[5] ? ALU_SUB : ALU_ADD;
          3'b001:  dec_s.alu_control = ALU_SLL;
          3'b010:  dec_s.alu_control = ALU_SLT;
          3'b011:  dec_s.alu_control = ALU_SLTU;
          3'b100:  dec_s.alu_control = ALU_XOR;
          3'b101:  dec_s.alu_control = funct7_s[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_s.alu_control = ALU_OR;
          3'b111:  dec_s.alu_control = ALU_AND;
          default: dec_s.alu_control = ALU_ADD;
        endcase
      end
      OPC_OPIMM: begin
        dec_s.use_imm = 1'b1;
        dec_s.rs2     = 5'd0;
        dec_s.imm     = {{20{instr[31]}}, instr[31:20]};
        case (funct3_s)
          3'b000:  dec_s.alu_control = ALU_ADD;
          3'b001: begin
            // Shift-immediates carry a 5-bit shamt; the upper bits must be clear.
            dec_s.alu_control = ALU_SLL;
            dec_s.imm         = {27'd0, instr[24:20]};
            bad_s             = (funct7_s != 7'b0000000);
          end
          3'b010:  dec_s.alu_control = ALU_SLT;
          3'b011:  dec_s.alu_control = ALU_SLTU;
          3'b100:  dec_s.alu_control = ALU_XOR;
          3'b101: begin
            dec_s.imm = {27'd0, instr[24:20]};
            if (funct7_s == 7'b0000000) begin
              dec_s.alu_control = ALU_SRL;
            end else if (funct7_s == 7'b0100000) begin
              dec_s.alu_control = ALU_SRA;
            end else begin
              bad_s = 1'b1;
            end
          end
          3'b110:  dec_s.alu_control = ALU_OR;
          3'b111:  dec_s.alu_control = ALU_AND;
          default: dec_s.alu_control = ALU_ADD;
        endcase
      end
      OPC_BRANCH: begin
        // Inverted branches (BNE/BGE/BGEU) share the ALU op of their partner.
        dec_s.is_branch = 1'b1;
        dec_s.br_invert = funct3_s[0];
        dec_s.imm       = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
        case (funct3_s)
          3'b000, 3'b001: dec_s.alu_control = ALU_SUB;
          3'b100, 3'b101: dec_s.alu_control = ALU_SLT;
          3'b110, 3'b111: dec_s.alu_control = ALU_SLTU;
          default:        bad_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_s.alu_control = ALU_ADD;
        dec_s.use_imm     = 1'b1;
        dec_s.rs2         = 5'd0;
        dec_s.imm         = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec_s.alu_control = ALU_ADD;
        dec_s.use_imm     = 1'b1;
        dec_s.rd          = 5'd0;
        dec_s.imm         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_LUI: begin
        dec_s.alu_control = ALU_ADD;
        dec_s.use_imm     = 1'b1;
        dec_s.rs1         = 5'd0;
        dec_s.rs2         = 5'd0;
        dec_s.imm         = {instr[31:12], 12'd0};
      end
      default: bad_s = 1'b1;
    endcase
    // Illegal words still travel downstream, carrying only the raw register fields.
    if (bad_s) begin
      dec_s             = '0;
      dec_s.rs1         = instr[19:15];
      dec_s.rs2         = instr[24:20];
      dec_s.rd          = instr[11:7];
      dec_s.illegal     = 1'b1;
    end else begin
      dec_s.illegal     = 1'b0;
    end
  end

`ifdef DECODE_SKID_EN
  dec_t skid_r;
  logic skid_valid_r;

  // Ready depends only on skid occupancy, so out_ready has no path to in_ready.
  assign in_ready_s = !rst && !skid_valid_r;

  // Output register with a 1-entry skid that absorbs the word accepted during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r        <= '0;
      out_valid_r  <= 1'b0;
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_r        <= dec_s;
        out_valid_r  <= 1'b1;
      end else begin
        out_valid_r  <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_r       <= dec_s;
        skid_valid_r <= 1'b1;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end
  end
`else
  // The stage can take a word whenever the output is empty or draining this cycle.
  assign in_ready_s = !rst && (!out_valid_r || out_ready);

  // Output register: refill on accept, clear valid on a drain with no refill, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_r       <= dec_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`endif

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign alu_control = out_r.alu_control;
  assign rs1         = out_r.rs1;
  assign rs2         = out_r.rs2;
  assign rd          = out_r.rd;
  assign imm         = out_r.imm;
  assign use_imm     = out_r.use_imm;
  assign is_branch   = out_r.is_branch;
  assign br_invert   = out_r.br_invert;
  assign illegal     = out_r.illegal;

endmodule
